// File: rtl/key_toggle_bank.sv
// Debounced key bank: per-key sync, press/release pulses, toggle state, optional
// long-press pulse (define KEY_LONG_PRESS_EN to build the long-press counters).
module key_toggle_chan #(
  parameter int HOLD_CYCLES = 500000,
  parameter int LONG_CYCLES = 50000000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_i,
  input  logic clear_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o,
  output logic long_o
);
  localparam int            CW       = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          IDLE_LVL = (ACTIVE_LOW != 0);

  if (HOLD_CYCLES < 2 || LONG_CYCLES <= HOLD_CYCLES) begin : g_bad_params
    $error("key_toggle_chan: need HOLD_CYCLES >= 2 and LONG_CYCLES > HOLD_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    sync_q, sync_d;
  logic          pressed, press_evt;
  logic          level_q, press_q, release_q;
  logic          toggle_q, toggle_d;

  // Synchronizer resets to the released pin level so a key held through reset
  // is seen as a fresh edge and fully re-debounced.
  always_comb sync_d = {sync_q[0], key_i};

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sync_q <= {2{IDLE_LVL}};
    else       sync_q <= sync_d;

  assign pressed   = sync_q[1] ^ IDLE_LVL;
  assign press_evt = (state_q == PRESS_WAIT) && pressed && (cnt_q == HOLD_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE:
          if (pressed) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        PRESS_WAIT:
          if (!pressed) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_MAX) begin
            state_q <= HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        HELD:
          if (!pressed) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        RELEASE_WAIT:
          if (pressed) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_MAX) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Clear beats a coincident press; the press pulse itself is unaffected.
  always_comb begin
    toggle_d = toggle_q;
    if (clear_i)        toggle_d = 1'b0;
    else if (press_evt) toggle_d = ~toggle_q;
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) toggle_q <= 1'b0;
    else       toggle_q <= toggle_d;

`ifdef KEY_LONG_PRESS_EN
  localparam int            LW       = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_CYCLES - 2);
  localparam logic [LW-1:0] LONG_ONE = LW'(1);

  logic [LW-1:0] long_cnt_q;
  logic          long_q;

  // Restarted only by a new press, so release bounces cannot re-arm it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_evt) begin
        long_cnt_q <= '0;
      end else if (level_q && long_cnt_q != LONG_MAX) begin
        long_cnt_q <= long_cnt_q + LONG_ONE;
        long_q     <= (long_cnt_q == LONG_PRE);
      end
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;
endmodule

module key_toggle_bank #(
  parameter int NUM_KEYS    = 4,
  parameter int HOLD_CYCLES = 500000,
  parameter int LONG_CYCLES = 50000000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_KEYS-1:0] key_i,
  input  logic [NUM_KEYS-1:0] clear_i,
  output logic [NUM_KEYS-1:0] key_level_o,
  output logic [NUM_KEYS-1:0] press_pulse_o,
  output logic [NUM_KEYS-1:0] release_pulse_o,
  output logic [NUM_KEYS-1:0] toggle_o,
  output logic [NUM_KEYS-1:0] long_pulse_o
);
  for (genvar n = 0; n < NUM_KEYS; n++) begin : g_chan
    key_toggle_chan #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk      (clk),
      .rstn     (rstn),
      .key_i    (key_i[n]),
      .clear_i  (clear_i[n]),
      .level_o  (key_level_o[n]),
      .press_o  (press_pulse_o[n]),
      .release_o(release_pulse_o[n]),
      .toggle_o (toggle_o[n]),
      .long_o   (long_pulse_o[n])
    );
  end
endmodule

// File: tb/tb_key_toggle_bank.sv
// Bench for key_toggle_bank: directed scenarios plus random key traffic against
// a run-length reference model of the debounce rules.
module tb_key_toggle_bank;
  localparam int NK   = 2;
  localparam int HOLD = 4;
  localparam int LONG = 10;

  logic          clk, rstn;
  logic [NK-1:0] key_i, clear_i;
  logic [NK-1:0] key_level_o, press_pulse_o, release_pulse_o, toggle_o, long_pulse_o;

  key_toggle_bank #(.NUM_KEYS(NK), .HOLD_CYCLES(HOLD), .LONG_CYCLES(LONG), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rstn(rstn), .key_i(key_i), .clear_i(clear_i),
    .key_level_o(key_level_o), .press_pulse_o(press_pulse_o),
    .release_pulse_o(release_pulse_o), .toggle_o(toggle_o), .long_pulse_o(long_pulse_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: debounced level flips once HOLD+1 consecutive synced samples
  // disagree with it; synced sample = pin value two edges earlier.
  logic [NK-1:0] exp_level, exp_press, exp_rel, exp_tog, exp_long;
  logic [NK-1:0] d1, d2;
  int            run [NK];
  int            age [NK];

  task automatic model_reset();
    exp_level = '0; exp_press = '0; exp_rel = '0; exp_tog = '0; exp_long = '0;
    d1 = '0; d2 = '0;
    for (int c = 0; c < NK; c++) begin run[c] = 0; age[c] = 0; end
  endtask

  task automatic model_step();
    logic [NK-1:0] raw;
    raw = ~key_i;
    exp_press = '0; exp_rel = '0; exp_long = '0;
    for (int c = 0; c < NK; c++) begin
      logic s, old;
      s = d2[c]; d2[c] = d1[c]; d1[c] = raw[c];
      old = exp_level[c];
      if (s != exp_level[c]) run[c]++;
      else                   run[c] = 0;
      if (run[c] == HOLD + 1) begin
        exp_level[c] = s;
        run[c] = 0;
        if (s) exp_press[c] = 1'b1;
        else   exp_rel[c]   = 1'b1;
      end
      if (clear_i[c])        exp_tog[c] = 1'b0;
      else if (exp_press[c]) exp_tog[c] = ~exp_tog[c];
      if (exp_press[c]) age[c] = 0;
      else if (old && age[c] < LONG - 1) begin
        age[c]++;
`ifdef KEY_LONG_PRESS_EN
        if (age[c] == LONG - 1) exp_long[c] = 1'b1;
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_step();
    #1;
    chk("level",   int'(key_level_o),     int'(exp_level));
    chk("press",   int'(press_pulse_o),   int'(exp_press));
    chk("release", int'(release_pulse_o), int'(exp_rel));
    chk("toggle",  int'(toggle_o),        int'(exp_tog));
    chk("long",    int'(long_pulse_o),    int'(exp_long));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first, np, nr, nl, lc, np1, nlvl, tmid;
    int dur [NK];
    logic [NK-1:0] pr;

    rstn = 1'b0; key_i = '1; clear_i = '0;
    model_reset();
    #2;
    idle(3);
    chk("rst_outs", int'({key_level_o, press_pulse_o, release_pulse_o, toggle_o, long_pulse_o}), 0);
    rstn = 1'b1;
    idle(4);

    // Clean press on key 0, held 30 cycles.
    key_i = 2'b10;
    first = -1; np1 = 0; nl = 0; lc = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (press_pulse_o[0] && first < 0) first = c;
      if (c == 7) begin
        chk("lvl_at7", int'(key_level_o[0]), 1);
        chk("tog_at7", int'(toggle_o[0]), 1);
      end
      if (c == 8) chk("press_one_cycle", int'(press_pulse_o[0]), 0);
      np1 += int'(press_pulse_o[1]) + int'(key_level_o[1]);
      if (long_pulse_o[0]) begin nl++; lc = c; end
    end
    chk("press_lat", first, 7);
    chk("ch1_silent", np1, 0);
`ifdef KEY_LONG_PRESS_EN
    chk("long_count", nl, 1);
    chk("long_cycle", lc, 16);
`else
    chk("long_count", nl, 0);
`endif
    key_i = 2'b11;
    idle(12);

    // 3-cycle glitch on key 0.
    key_i = 2'b10;
    idle(3);
    key_i = 2'b11;
    np = 0; nlvl = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      np   += int'(press_pulse_o[0]) + int'(release_pulse_o[0]);
      nlvl += int'(key_level_o[0]);
    end
    chk("glitch_pulses", np, 0);
    chk("glitch_level", nlvl, 0);

    // Two press/release cycles of 8 cycles per phase, toggle cleared first.
    clear_i = 2'b01;
    tick();
    clear_i = '0;
    chk("tog_cleared", int'(toggle_o[0]), 0);
    np = 0; nr = 0; tmid = -1;
    for (int r = 0; r < 2; r++) begin
      key_i = 2'b10;
      for (int c = 0; c < 8; c++) begin
        tick();
        np += int'(press_pulse_o[0]); nr += int'(release_pulse_o[0]);
      end
      if (r == 0) tmid = int'(toggle_o[0]);
      key_i = 2'b11;
      for (int c = 0; c < 8; c++) begin
        tick();
        np += int'(press_pulse_o[0]); nr += int'(release_pulse_o[0]);
      end
    end
    chk("pp_presses", np, 2);
    chk("pp_releases", nr, 2);
    chk("pp_tog_mid", tmid, 1);
    chk("pp_tog_end", int'(toggle_o[0]), 0);
    idle(4);

    // Clear on key 1 coincident with its press recognition.
    key_i = 2'b01;
    idle(6);
    clear_i = 2'b10;
    tick();
    clear_i = '0;
    chk("clr_press", int'(press_pulse_o[1]), 1);
    chk("clr_tog", int'(toggle_o[1]), 0);
    key_i = 2'b11;
    idle(12);

    // Reset in the middle of a key 0 press, key held through it.
    key_i = 2'b10;
    idle(5);
    rstn = 1'b0;
    #1;
    chk("midrst_outs", int'({key_level_o, press_pulse_o, release_pulse_o, toggle_o, long_pulse_o}), 0);
    idle(2);
    rstn = 1'b1;
    first = -1; nr = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (press_pulse_o[0] && first < 0) first = c;
      nr += int'(release_pulse_o[0]);
    end
    chk("rst_fresh_press", first, 7);
    chk("rst_no_release", nr, 0);
    key_i = 2'b11;
    idle(12);

    // Random traffic: mixed glitches and real presses, random clears, rare resets.
    pr = '0;
    for (int c = 0; c < NK; c++) dur[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NK; c++) begin
        if (dur[c] == 0) begin
          pr[c]  = ~pr[c];
          dur[c] = $urandom_range(1, 12);
        end
        dur[c]--;
      end
      key_i   = ~pr;
      clear_i = NK'($urandom_range(0, 15) == 0 ? $urandom_range(1, 3) : 0);
      if (!rstn)                              rstn = 1'b1;
      else if ($urandom_range(0, 299) == 0)   rstn = 1'b0;
      tick();
    end
    rstn = 1'b1; key_i = '1; clear_i = '0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
